imem_fetch_unit: RTL and testbench
==================================

Name: imem_fetch_unit

Overview:
Parametrised synchronous instruction memory with a valid/ready fetch interface, registered read data and a program-load port. It sits between the PC/fetch stage and decode of the ARMv8 core. It adds what a bare combinational instruction ROM lacks:
- clock and reset, with memory cleared to NOP after reset;
- byte-addressed PC with a base offset;
- alignment and range fault reporting;
- runtime program loading;
- back-pressure.

Parameters:
ADDR_W, 32, width of the fetch PC in bits
DATA_W, 32, instruction word width in bits (fixed to 32 for A64; other values used only for test)
DEPTH, 32, number of instruction words (power of two, at least 2)
BASE_ADDR, 32'h0000_0000, byte address of word 0 (DEPTH*4-aligned)
NOP_WORD, 32'hD503201F, fill value after reset and returned data on fault

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  fetch request valid
req_ready  out  1  fetch request accepted when high with req_valid
req_pc  in  ADDR_W  byte address of instruction
rsp_valid  out  1  response valid
rsp_ready  in  1  consumer accepts response
rsp_instr  out  DATA_W  fetched instruction
rsp_pc  out  ADDR_W  PC of the returned instruction
rsp_fault  out  2  00 ok, 01 misaligned, 10 out of range
ld_en  in  1  program-load write strobe
ld_ready  out  1  load port accepting writes (equals init_done)
ld_addr  in  clog2(DEPTH)  word index to write
ld_data  in  DATA_W  word to write
init_done  out  1  memory clear complete

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous, active-low.
- Reset values: state=INIT, init ptr=0, req_ready=0, rsp_valid=0, rsp_instr=NOP_WORD, rsp_pc=0, rsp_fault=00, init_done=0, ld_ready=0.
- FSM states: INIT, IDLE, RESP.
- INIT state:
  - Writes NOP_WORD to word ptr each cycle; ptr increments.
  - After DEPTH cycles (ptr==DEPTH-1 written) → IDLE and init_done=1.
  - req_ready=0 throughout; ld_en is ignored.
- IDLE state:
  - req_ready=1.
  - On req_valid&req_ready, capture the request → RESP next edge.
  - rsp_valid=1 on the cycle after acceptance (1-cycle latency).
- RESP state:
  - rsp_valid=1; rsp_instr/rsp_pc/rsp_fault are held stable until rsp_ready.
  - req_ready = rsp_ready, so back-to-back fetches sustain 1 per cycle.
  - rsp_ready & new accept → stay RESP with new data.
  - rsp_ready & no request → IDLE, rsp_valid=0.
- Address decode:
  - off = req_pc - BASE_ADDR; word index = off[clog2(DEPTH)+1:2].
  - req_pc[1:0]!=0 → fault 01.
  - Otherwise req_pc<BASE_ADDR or off>=DEPTH*4 → fault 10.
  - Misaligned has priority over out of range.
  - Any fault → rsp_instr=NOP_WORD; memory is not read.
- Load port:
  - When init_done, ld_en writes ld_data to mem[ld_addr] at the edge.
  - A fetch accepted in the same cycle to the same word returns the OLD word (read-before-write); the next fetch sees the new word.
  - ld_addr is always in range because its width equals clog2(DEPTH).
- Reset mid-operation: outputs return immediately to reset values; any pending response is dropped; INIT restarts from word 0; loaded program contents are lost.
- rsp_pc is the captured req_pc, unmodified.

Optional Feature:
- Macro: IMEM_PERF_CNT_EN.
- When defined, adds outputs:
  - perf_fetch_cnt[31:0]: increments on every accepted request.
  - perf_fault_cnt[15:0]: increments on every accepted request that faults.
  - Both reset to 0, wrap at max, count only after init_done.
- When undefined, these ports and registers are absent and behaviour is otherwise identical.

Test Plan:
- Reset then hold rst_n=1 → init_done rises after exactly DEPTH(32) cycles; fetch pc=0x10 → rsp_instr=0xD503201F, fault 00.
- Load words 0..3 = 8B1F03E5, F84000A4, 8B040086, F80010A6; fetch pc 0,4,8,C back-to-back with rsp_ready=1 → four consecutive rsp_valid cycles with those words and rsp_pc 0,4,8,C.
- Fetch pc=0x6 → fault 01, instr NOP. Fetch pc=0x80 (DEPTH=32) → fault 10. Fetch pc=0x82 → fault 01.
- Hold rsp_ready=0 for 3 cycles while req_valid=1 → req_ready=0, rsp_* stable; release → next request accepted that cycle.
- ld_en to word 2 = 0x12345678 in the same cycle as fetch pc=8 → response 8B040086; the following fetch of 8 → 0x12345678.
- Assert rst_n=0 mid-RESP → rsp_valid drops immediately; after release init_done=0 for 32 cycles; word 0 reads NOP. With IMEM_PERF_CNT_EN: 5 fetches, 2 faulting → 5/2.

Source files
------------

// File: rtl/imem_fetch_unit.sv
// Instruction memory with a valid/ready fetch port, registered response, program-load port and NOP clear after reset.
// Optional fetch/fault performance counters are enabled by defining IMEM_PERF_CNT_EN.
module imem_fetch_unit #(
    parameter int unsigned        ADDR_W    = 32,
    parameter int unsigned        DATA_W    = 32,
    parameter int unsigned        DEPTH     = 32,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = '0,
    parameter logic [DATA_W-1:0]  NOP_WORD  = DATA_W'(32'hD503201F)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [ADDR_W-1:0]          req_pc,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [DATA_W-1:0]          rsp_instr,
    output logic [ADDR_W-1:0]          rsp_pc,
    output logic [1:0]                 rsp_fault,
    input  logic                       ld_en,
    output logic                       ld_ready,
    input  logic [$clog2(DEPTH)-1:0]   ld_addr,
    input  logic [DATA_W-1:0]          ld_data,
`ifdef IMEM_PERF_CNT_EN
    output logic [31:0]                perf_fetch_cnt,
    output logic [15:0]                perf_fault_cnt,
`endif
    output logic                       init_done
);

    localparam int unsigned        AW   = $clog2(DEPTH);
    localparam logic [ADDR_W:0]    SPAN = (ADDR_W+1)'(DEPTH * 4);

    typedef enum logic [1:0] {INIT, IDLE, RESP} state_t;

    state_t             state, state_nxt;
    logic [AW-1:0]      init_ptr;
    logic [DATA_W-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0]  off;
    logic [AW-1:0]      idx;
    logic [1:0]         fault;
    logic               accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= INIT;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            INIT: if (init_ptr == AW'(DEPTH - 1)) state_nxt = IDLE;
            IDLE: if (accept) state_nxt = RESP;
            RESP: if (rsp_ready && !accept) state_nxt = IDLE;
            default: state_nxt = INIT;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        init_done = 1'b1;
        case (state)
            INIT: init_done = 1'b0;
            IDLE: req_ready = 1'b1;
            RESP: begin
                req_ready = rsp_ready;
                rsp_valid = 1'b1;
            end
            default: init_done = 1'b0;
        endcase
    end

    assign ld_ready = init_done;
    assign accept   = req_valid && req_ready;

    // Misalignment is tested first so it wins over the range check.
    always_comb begin
        off   = req_pc - BASE_ADDR;
        idx   = off[AW+1:2];
        fault = 2'b00;
        if (req_pc[1:0] != 2'b00)
            fault = 2'b01;
        else if ((req_pc < BASE_ADDR) || ({1'b0, off} >= SPAN))
            fault = 2'b10;
    end

    // No reset on the array: INIT sweeps every word to NOP before any fetch is accepted.
    always_ff @(posedge clk) begin
        if (state == INIT)
            mem[init_ptr] <= NOP_WORD;
        else if (ld_en)
            mem[ld_addr] <= ld_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_ptr  <= '0;
            rsp_instr <= NOP_WORD;
            rsp_pc    <= '0;
            rsp_fault <= 2'b00;
        end else begin
            if (state == INIT)
                init_ptr <= init_ptr + AW'(1);
            if (accept) begin
                rsp_pc    <= req_pc;
                rsp_fault <= fault;
                rsp_instr <= (fault != 2'b00) ? NOP_WORD : mem[idx];
            end
        end
    end

`ifdef IMEM_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_cnt <= '0;
            perf_fault_cnt <= '0;
        end else if (accept) begin
            perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (fault != 2'b00)
                perf_fault_cnt <= perf_fault_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Randomized bench for imem_fetch_unit against a transaction-level memory/response model.
// Define IMEM_PERF_CNT_EN for both files to also check the performance counters.
module tb_imem_fetch_unit;

    localparam int unsigned DEPTH = 32;
    localparam logic [31:0] BASE  = 32'h0;
    localparam logic [31:0] NOP   = 32'hD503201F;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_pc = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_instr;
    logic [31:0] rsp_pc;
    logic [1:0]  rsp_fault;
    logic        ld_en = 1'b0;
    logic        ld_ready;
    logic [4:0]  ld_addr = '0;
    logic [31:0] ld_data = '0;
    logic        init_done;
`ifdef IMEM_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [15:0] perf_fault_cnt;
`endif

    imem_fetch_unit #(
        .ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .BASE_ADDR(BASE), .NOP_WORD(NOP)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_pc(req_pc),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr),
        .rsp_pc(rsp_pc), .rsp_fault(rsp_fault),
        .ld_en(ld_en), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
`ifdef IMEM_PERF_CNT_EN
        .perf_fetch_cnt(perf_fetch_cnt), .perf_fault_cnt(perf_fault_cnt),
`endif
        .init_done(init_done)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: memory image plus the single outstanding response.
    logic [31:0] m_mem [DEPTH];
    int unsigned m_init_cnt;
    bit          m_done, m_pend;
    logic [31:0] m_instr, m_pc;
    logic [1:0]  m_fault;
    int unsigned m_fetch, m_faultc;

    function automatic logic [1:0] fault_of(input logic [31:0] pc);
        if (pc % 4 != 0) return 2'b01;
        if (pc < BASE || (pc - BASE) >= DEPTH * 4) return 2'b10;
        return 2'b00;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = NOP;
        m_init_cnt = 0; m_done = 0; m_pend = 0;
        m_instr = NOP; m_pc = '0; m_fault = 2'b00;
        m_fetch = 0; m_faultc = 0;
    endtask

    // Called at a negedge: drive, sample the pre-edge outputs, advance the model over the edge, return at next negedge.
    task automatic step(input logic v, input logic [31:0] pc, input logic rr,
                        input logic le, input logic [4:0] la, input logic [31:0] ld);
        bit acc;
        logic [1:0] f;
        req_valid = v; req_pc = pc; rsp_ready = rr;
        ld_en = le; ld_addr = la; ld_data = ld;
        #1;
        acc = m_done && v && (!m_pend || rr);
        check("req_ready", req_ready, m_done && (!m_pend || rr));
        check("rsp_valid", rsp_valid, m_pend);
        check("init_done", init_done, m_done);
        check("ld_ready",  ld_ready,  m_done);
        check("rsp_instr", rsp_instr, m_instr);
        check("rsp_pc",    rsp_pc,    m_pc);
        check("rsp_fault", rsp_fault, m_fault);
`ifdef IMEM_PERF_CNT_EN
        check("perf_fetch", perf_fetch_cnt, m_fetch);
        check("perf_fault", perf_fault_cnt, m_faultc & 16'hFFFF);
`endif
        @(posedge clk);
        if (!m_done) begin
            m_init_cnt++;
            if (m_init_cnt == DEPTH) m_done = 1;
        end else begin
            if (acc) begin
                f = fault_of(pc);
                m_instr = (f != 2'b00) ? NOP : m_mem[(pc - BASE) / 4];
                m_pc = pc; m_fault = f; m_pend = 1;
                m_fetch++;
                if (f != 2'b00) m_faultc++;
            end else if (rr) begin
                m_pend = 0;
            end
            if (le) m_mem[la] = ld;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step(1'b0, '0, 1'b1, 1'b0, '0, '0);
    endtask

    logic [31:0] prog [4];
    logic [31:0] rpc;
    int unsigned sel;

    initial begin
        prog[0] = 32'h8B1F03E5; prog[1] = 32'hF84000A4;
        prog[2] = 32'h8B040086; prog[3] = 32'hF80010A6;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_req_ready", req_ready, 1'b0);
        check("rst_rsp_instr", rsp_instr, NOP);
        rst_n = 1'b1;

        idle(DEPTH + 1);
        step(1'b1, 32'h10, 1'b1, 1'b0, '0, '0);
        check("first_instr", rsp_instr, 32'hD503201F);
        check("first_fault", rsp_fault, 2'b00);
        idle(1);

        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b1, 5'(i), prog[i]);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 32'(i * 4), 1'b1, 1'b0, '0, '0);
            check("prog_valid", rsp_valid, 1'b1);
            check("prog_instr", rsp_instr, prog[i]);
            check("prog_pc", rsp_pc, 32'(i * 4));
        end
        idle(1);

        step(1'b1, 32'h6, 1'b1, 1'b0, '0, '0);
        check("mis_fault", rsp_fault, 2'b01);
        check("mis_instr", rsp_instr, NOP);
        step(1'b1, 32'h80, 1'b1, 1'b0, '0, '0);
        check("oor_fault", rsp_fault, 2'b10);
        step(1'b1, 32'h82, 1'b1, 1'b0, '0, '0);
        check("mis_oor_fault", rsp_fault, 2'b01);
        idle(1);

        step(1'b1, 32'h0, 1'b1, 1'b0, '0, '0);
        repeat (3) step(1'b1, 32'h4, 1'b0, 1'b0, '0, '0);
        step(1'b1, 32'h4, 1'b1, 1'b0, '0, '0);
        check("stall_release_instr", rsp_instr, prog[1]);
        idle(1);

        step(1'b1, 32'h8, 1'b1, 1'b1, 5'd2, 32'h12345678);
        check("rbw_old", rsp_instr, 32'h8B040086);
        step(1'b1, 32'h8, 1'b1, 1'b0, '0, '0);
        check("rbw_new", rsp_instr, 32'h12345678);

        step(1'b1, 32'h0, 1'b0, 1'b0, '0, '0);
        rst_n = 1'b0;
        #1;
        check("midrst_rsp_valid", rsp_valid, 1'b0);
        check("midrst_init_done", init_done, 1'b0);
        check("midrst_rsp_pc", rsp_pc, 32'h0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(DEPTH + 1);
        step(1'b1, 32'h0, 1'b1, 1'b0, '0, '0);
        check("post_rst_word0", rsp_instr, NOP);
        step(1'b1, 32'h4, 1'b1, 1'b0, '0, '0);
        step(1'b1, 32'h3, 1'b1, 1'b0, '0, '0);
        step(1'b1, 32'h8, 1'b1, 1'b0, '0, '0);
        step(1'b1, 32'h200, 1'b1, 1'b0, '0, '0);
        idle(1);
`ifdef IMEM_PERF_CNT_EN
        check("perf_fetch_5", perf_fetch_cnt, 32'd5);
        check("perf_fault_2", perf_fault_cnt, 16'd2);
`endif

        for (int i = 0; i < 400; i++) begin
            sel = $urandom_range(0, 9);
            if (sel < 6)      rpc = 32'($urandom_range(0, DEPTH - 1) * 4);
            else if (sel < 8) rpc = 32'($urandom_range(0, DEPTH * 4 - 1)) | 32'h1;
            else              rpc = 32'h80 + 32'($urandom_range(0, 255) * 4);
            step(1'($urandom_range(0, 3) != 0), rpc, 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 3) == 0), 5'($urandom_range(0, DEPTH - 1)), $urandom);
        end
        idle(2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
